// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - register map and CTL bit positions shared by the tick timer.
// Optional interrupt enables are selected by TMR_IRQ_EN.
package tmr_pkg;

  localparam logic [3:0] ADDR_TICKS  = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam int         CH_BASE     = 2;
  localparam int         CH_STRIDE   = 2;

  localparam int CTL_EN  = 0;
  localparam int CTL_PER = 1;
  localparam int CTL_IE  = 2;

  function automatic logic [3:0] cnt_addr(input int c);
    return 4'(CH_BASE + CH_STRIDE * c);
  endfunction

  function automatic logic [3:0] ctl_addr(input int c);
    return 4'(CH_BASE + CH_STRIDE * c + 1);
  endfunction

endpackage

// File: rtl/tmr_multi_if.sv
// rtl/tmr_multi_if.sv - word-addressed register bus between the CPU and the tick timer.
interface tmr_multi_if;
  logic        en;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output en, output wr, output addr, output din, input dout);
  modport slave  (input en, input wr, input addr, input din, output dout);
endinterface

// File: rtl/tmr_chan.sv
// rtl/tmr_chan.sv - one down-counting timer channel with reload and CTL bits.
// The ie bit exists only when TMR_IRQ_EN is defined.
module tmr_chan
  import tmr_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 load,
  input  logic                 ctl_wr,
  input  logic [31:0]          din,
  output logic [CNT_WIDTH-1:0] count,
  output logic [2:0]           ctl,
  output logic                 expire
);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] reload_q, reload_d;
  logic                 en_q, en_d;
  logic                 per_q, per_d;
  logic                 ie_q, ie_d;

  // A CTL write lands before the tick is evaluated, so enabling on a tick edge counts it.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    per_d    = per_q;
    ie_d     = ie_q;
    expire   = 1'b0;
    if (ctl_wr) begin
      en_d  = din[CTL_EN];
      per_d = din[CTL_PER];
`ifdef TMR_IRQ_EN
      ie_d  = din[CTL_IE];
`endif
    end
    if (load) begin
      count_d  = din[CNT_WIDTH-1:0];
      reload_d = din[CNT_WIDTH-1:0];
    end else if (tick && en_d) begin
      if (count_q > CNT_WIDTH'(1)) begin
        count_d = count_q - CNT_WIDTH'(1);
      end else if (count_q == CNT_WIDTH'(1)) begin
        expire = 1'b1;
        if (per_d) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      ie_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      per_q    <= per_d;
      ie_q     <= ie_d;
    end
  end

  assign count = count_q;
  assign ctl   = {ie_q, per_q, en_q};

endmodule

// File: rtl/tmr_multi.sv
// rtl/tmr_multi.sv - prescaled tick counter with NCHAN interrupting timer channels.
// irq is driven only when TMR_IRQ_EN is defined; otherwise it is tied low.
module tmr_multi
  import tmr_pkg::*;
#(
  parameter int CLK_PER_TICK = 25000,
  parameter int CNT_WIDTH    = 32,
  parameter int NCHAN        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tmr_multi_if.slave       bus,
  output logic [NCHAN-1:0] irq
);

  localparam int PW = $clog2(CLK_PER_TICK);

  logic [PW-1:0]        presc_q, presc_d;
  logic [CNT_WIDTH-1:0] ticks_q, ticks_d;
  logic [NCHAN-1:0]     pending_q, pending_d;
  logic [NCHAN-1:0]     load, ctl_wr, expire, clr;
  logic [CNT_WIDTH-1:0] ch_count [NCHAN];
  logic [2:0]           ch_ctl   [NCHAN];
  logic                 tick, wr_en, rd_en;
  logic [31:0]          rdata;

  assign wr_en = bus.en & bus.wr;
  assign rd_en = bus.en & ~bus.wr;
  assign tick  = (presc_q == PW'(CLK_PER_TICK - 1));

  always_comb begin
    load   = '0;
    ctl_wr = '0;
    for (int c = 0; c < NCHAN; c++) begin
      load[c]   = wr_en && (bus.addr == cnt_addr(c));
      ctl_wr[c] = wr_en && (bus.addr == ctl_addr(c));
    end
    clr = (wr_en && bus.addr == ADDR_STATUS) ? bus.din[NCHAN-1:0] : '0;
  end

  // Software writes beat the tick for TICKS; an expiry beats a STATUS clear.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    ticks_d = ticks_q;
    if (wr_en && bus.addr == ADDR_TICKS) begin
      ticks_d = bus.din[CNT_WIDTH-1:0];
    end else if (tick) begin
      ticks_d = ticks_q + CNT_WIDTH'(1);
    end
    pending_d = (pending_q & ~clr) | expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      ticks_q   <= '0;
      pending_q <= '0;
    end else begin
      presc_q   <= presc_d;
      ticks_q   <= ticks_d;
      pending_q <= pending_d;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    tmr_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .load   (load[c]),
      .ctl_wr (ctl_wr[c]),
      .din    (bus.din),
      .count  (ch_count[c]),
      .ctl    (ch_ctl[c]),
      .expire (expire[c])
    );
  end

  always_comb begin
    rdata = '0;
    if (bus.addr == ADDR_TICKS) begin
      rdata = 32'(ticks_q);
    end else if (bus.addr == ADDR_STATUS) begin
      rdata = 32'(pending_q);
    end
    for (int c = 0; c < NCHAN; c++) begin
      if (bus.addr == cnt_addr(c)) rdata = 32'(ch_count[c]);
      if (bus.addr == ctl_addr(c)) rdata = {29'b0, ch_ctl[c]};
    end
  end

  assign bus.dout = rd_en ? rdata : '0;

`ifdef TMR_IRQ_EN
  always_comb begin
    irq = '0;
    for (int c = 0; c < NCHAN; c++) begin
      irq[c] = pending_q[c] & ch_ctl[c][CTL_IE];
    end
  end
`else
  assign irq = '0;
`endif

endmodule

// File: tb/tb_tmr_multi.sv
// tb/tb_tmr_multi.sv - directed scoreboard bench for tmr_multi (CLK_PER_TICK=4, NCHAN=2).
// Expected irq and CTL ie values follow TMR_IRQ_EN.
module tb_tmr_multi;

`ifdef TMR_IRQ_EN
  localparam bit HAS_IE = 1'b1;
`else
  localparam bit HAS_IE = 1'b0;
`endif

  localparam logic [3:0] A_TICKS = 4'd0, A_STATUS = 4'd1;
  localparam logic [3:0] A_CNT0 = 4'd2, A_CTL0 = 4'd3, A_CNT1 = 4'd4, A_CTL1 = 4'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] irq;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] exp_q[$];

  tmr_multi_if bus();

  tmr_multi #(.CLK_PER_TICK(4), .CNT_WIDTH(32), .NCHAN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string tag);
    expect_val(e);
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    check(tag, bus.dout);
    bus.en = 1'b0;
  endtask

  task automatic irq_chk(input logic [1:0] e, input string tag);
    expect_val(32'(e));
    check(tag, 32'(irq));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.en = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int first_at;
    int last_at;
    logic [31:0] st;
    bus.en = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.din = '0;
    step(2);
    rst_n = 1'b1;

    rd_chk(A_TICKS, 32'd0, "rst_ticks");
    rd_chk(A_STATUS, 32'd0, "rst_status");
    rd_chk(A_CNT0, 32'd0, "rst_cnt0");
    irq_chk(2'b00, "rst_irq");

    step(40);
    rd_chk(A_TICKS, 32'd10, "ticks_after_40");
    irq_chk(2'b00, "irq_idle");
    bus.addr = A_TICKS; bus.en = 1'b0;
    expect_val(32'd0);
    #1 check("dout_en_low", bus.dout);

    wr(A_CNT0, 32'd3);
    wr(A_CTL0, 32'b101);
    step(9);
    rd_chk(A_STATUS, 32'd0, "oneshot_not_yet");
    rd_chk(A_CNT0, 32'd1, "oneshot_cnt_1");
    step(1);
    rd_chk(A_STATUS, 32'd1, "oneshot_pending");
    irq_chk({1'b0, HAS_IE}, "oneshot_irq");
    rd_chk(A_CTL0, HAS_IE ? 32'b100 : 32'b000, "oneshot_ctl");
    rd_chk(A_CNT0, 32'd0, "oneshot_cnt_0");
    wr(A_STATUS, 32'b01);
    rd_chk(A_STATUS, 32'd0, "status_clear");
    irq_chk(2'b00, "irq_cleared");
    step(80);
    rd_chk(A_STATUS, 32'd0, "oneshot_no_refire");

    wr(A_CNT1, 32'd2);
    wr(A_CTL1, 32'b111);
    pulses = 0; first_at = -1; last_at = -1;
    for (int i = 0; i < 40; i++) begin
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = A_STATUS;
      #1 st = bus.dout;
      bus.en = 1'b0;
      if (st[1]) begin
        pulses++;
        irq_chk({HAS_IE, 1'b0}, "periodic_irq");
        if (first_at < 0) first_at = i;
        else begin
          expect_val(32'd8);
          check("periodic_gap", 32'(i - last_at));
        end
        last_at = i;
        wr(A_STATUS, 32'b10);
      end else begin
        @(negedge clk);
      end
    end
    expect_val(32'd5);
    check("periodic_pulses", 32'(pulses));
    expect_val(32'd5);
    check("periodic_first", 32'(first_at));

    wr(A_CNT0, 32'd1);
    wr(A_CTL0, 32'b111);
    step(6);
    wr(A_STATUS, 32'b01);
    rd_chk(A_STATUS, 32'b11, "set_beats_clear");
    wr(A_STATUS, 32'b01);
    rd_chk(A_STATUS, 32'b10, "clear_no_expiry");
    wr(A_CTL0, 32'd0);
    step(8);
    rd_chk(A_CNT0, 32'd1, "disabled_holds");
    rd_chk(A_STATUS, 32'b10, "disabled_no_fire");

    wr(A_TICKS, 32'hFFFF_FFFF);
    rd_chk(A_TICKS, 32'hFFFF_FFFF, "ticks_loaded");
    step(1);
    rd_chk(A_TICKS, 32'd0, "ticks_wrap");
    step(3);
    wr(A_TICKS, 32'h1234);
    rd_chk(A_TICKS, 32'h1234, "ticks_write_wins");
    step(4);
    rd_chk(A_TICKS, 32'h1235, "ticks_after_write");

    step(3);
    wr(A_CNT1, 32'd5);
    rd_chk(A_CNT1, 32'd5, "cnt_write_wins");
    step(4);
    rd_chk(A_CNT1, 32'd4, "cnt_after_write");

    step(3);
    rd_chk(A_STATUS, 32'b10, "pre_enable_status");
    wr(A_CTL0, 32'b001);
    rd_chk(A_STATUS, 32'b11, "enable_on_tick");
    rd_chk(A_CTL0, 32'd0, "enable_on_tick_ctl");
    rd_chk(A_CNT0, 32'd0, "enable_on_tick_cnt");

    #2 rst_n = 1'b0;
    #1 irq_chk(2'b00, "async_rst_irq");
    rd_chk(A_STATUS, 32'd0, "async_rst_status");
    rd_chk(A_CNT1, 32'd0, "async_rst_cnt1");
    rd_chk(A_CTL1, 32'd0, "async_rst_ctl1");
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    rd_chk(A_TICKS, 32'd0, "post_rst_3");
    step(1);
    rd_chk(A_TICKS, 32'd1, "post_rst_4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_multi.md
# tmr_multi

Parametrised tick timer with a free-running tick counter and NCHAN programmable down-counting channels, each raising a sticky interrupt on expiry in one-shot or periodic mode. Sits on the CPU's I/O bus next to the other memory-mapped peripherals. It replaces the fixed millisecond timer: the tick period, counter width and channel count are set by parameter, and a word-addressed register port gives the CPU read and write access.

## Interface
- CLK_PER_TICK, 25000, clk cycles per tick (≥2); 25000 gives 1 ms at 25 MHz
- CNT_WIDTH, 32, width of tick counter and channel counters (≤32)
- NCHAN, 2, number of channels (1..7)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  bus strobe for this block
- wr  in  1  1 = write, 0 = read; qualified by en
- addr  in  4  word address
- din  in  32  write data
- dout  out  32  read data; combinational
- irq  out  NCHAN  per-channel interrupt = pending[c] & ie[c]

## Operation
- Prescaler: counts 0..CLK_PER_TICK-1 and wraps. tick = (prescaler == CLK_PER_TICK-1).
- Tick counter: increments by 1 on each tick. Wraps modulo 2^CNT_WIDTH.
- Register map, unused addresses read 0, writes to them are ignored:
  - 0 TICKS: read returns the tick counter, zero-extended to 32 bits. Write loads din[CNT_WIDTH-1:0].
  - 1 STATUS: read returns pending[NCHAN-1:0]. Write 1 to bit c to clear pending[c].
  - 2+2c CNT_c: write sets reload_c and count_c to din. Read returns count_c.
  - 3+2c CTL_c: bit0 = enable, bit1 = periodic, bit2 = ie. Read returns these bits; all other bits read 0.
- Channel c, on a tick while enabled:
  - count_c > 1: decrement.
  - count_c == 1 (expiry): set pending[c]. If periodic, count_c ← reload_c; otherwise count_c ← 0 and enable ← 0.
  - count_c == 0: no change and no expiry. A reload value of 0 never fires.
- Resulting period: a channel loaded with N expires on the Nth tick after it is enabled.
- A disabled channel holds count_c.
- Reset values: all outputs and all state are 0. That is prescaler, tick counter, counts, reloads, CTL, pending, irq = 0 and dout = 0.

## Timing
- Register writes take effect at the clock edge where en & wr is high. The new value is readable in the next cycle.
- Reads are combinational, with zero latency: dout is valid in the same cycle that en & !wr and addr are presented. dout is 0 when en is low.
- irq is registered. It rises in the cycle after the expiry edge's tick cycle, i.e. it follows pending with no extra delay.
- Simultaneous events in one cycle:
  - TICKS write and tick: the write wins.
  - CNT_c write and tick: the write wins, with no decrement or expiry that cycle.
  - STATUS clear and expiry on the same bit: set wins, so pending stays 1.
  - CTL_c write enabling a channel and tick: the tick is applied using the new enable.
- rst_n assertion mid-operation clears everything immediately, independent of clk. Counting resumes from 0 on the first edge after deassertion; the first tick comes CLK_PER_TICK cycles later.

## Configuration
- TMR_IRQ_EN defined:
  - ie bits are implemented.
  - irq behaves as specified above.
- TMR_IRQ_EN undefined:
  - irq is tied to 0.
  - CTL bit2 reads 0 and writes to it are ignored.
  - pending and STATUS still operate, so software can poll.

## Structure
- Package tmr_pkg holds:
  - register address constants (TICKS, STATUS, CNT/CTL base and stride)
  - CTL bit positions (EN, PER, IE)
- Sub-module tmr_chan, instantiated NCHAN times. It holds count, reload and CTL for one channel, with inputs tick, load, ctl_wr, din. It outputs count, ctl and an expire pulse.
- The top level holds the prescaler, the tick counter, the pending register, the address decode and the read mux.

## Test plan
Run all scenarios with CLK_PER_TICK=4, NCHAN=2, CNT_WIDTH=32.
- Reset then free-run 40 cycles -> TICKS reads 10; irq = 0.
- CNT_0 ← 3, CTL_0 ← 0b101 (one-shot, ie) -> pending[0] and irq[0] set on the 3rd tick; CTL_0 reads 0b100; CNT_0 reads 0; no further expiry over 20 more ticks.
- CNT_1 ← 2, CTL_1 ← 0b111 (periodic); write STATUS=0b10 after each expiry -> irq[1] pulses every 2 ticks (8 cycles), 5 times in 40 cycles.
- Write STATUS=0b01 in the exact cycle channel 0 expires again (periodic, reload 1) -> pending[0] stays 1.
- TICKS ← 0xFFFFFFFF, wait 1 tick -> TICKS reads 0; a TICKS write coincident with a tick leaves the written value.
- Assert rst_n low mid-count with channel 1 periodic -> count, CTL, pending, irq are 0 before the next clk edge; after release, TICKS reads 1 exactly 4 cycles after the first edge.
